imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the TinyRV1 pipeline: the memory-side end of the processor's `imemreq`/`imemresp` fetch interface. It accepts one fetch request per cycle from the F stage. Each request is returned, in order, after a fixed, parameterised latency through a response pipeline. A backdoor load port lets test benches preload program images, and out-of-range or misaligned fetches are flagged rather than silently aliased.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words stored. Must be a power of two, ≥ 4. `AW = $clog2(DEPTH_WORDS)`.
- `LATENCY`, default 1: cycles from request edge to response valid. Legal range 1..4.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imemreq_val`  in  1  fetch request valid this cycle. No backpressure; the block always accepts.
- `imemreq_addr`  in  32  byte address of the fetch.
- `imemresp_val`  out  1  response valid.
- `imemresp_data`  out  32  fetched instruction word.
- `imemresp_err`  out  1  response is for a misaligned or out-of-range address.
- `load_en`  in  1  backdoor write enable.
- `load_addr`  in  32  backdoor byte address (word-aligned).
- `load_data`  in  32  backdoor write data.
- `busy`  out  1  one or more responses in flight in the pipeline.

## Operation
- Storage: `DEPTH_WORDS` × 32 array, indexed by word index `addr[AW+1:2]`. Contents are not reset and are undefined until loaded.
- Request classification at the accept edge:
  - misaligned if `addr[1:0] != 0`;
  - out-of-range if `addr[31:AW+2] != 0`;
  - `err = misaligned | out_of_range`.
- Read: the array is read combinationally at the accept cycle.
  - If `err` = 0, the stage-0 data is the word at the index.
  - If `err` = 1, the stage-0 data is forced to `32'h00000000`.
- Response pipeline: `LATENCY` stages, each holding {val, data, err}.
  - Stage 0 captures {`imemreq_val`, read data, err & `imemreq_val`} every cycle.
  - Each later stage copies the previous one.
  - Outputs are driven from the last stage.
  - When val is 0, stored data and err are 0. Idle outputs are all-zero, never X.
- Ordering: strictly FIFO. Throughput is one request per cycle sustained, with no bubbles inserted.
- Load port:
  - If `load_en` = 1 and `load_addr` is aligned and in range, `load_data` is written at the rising edge.
  - A misaligned or out-of-range load is dropped silently.
  - Loads are independent of request traffic.
- Read/write collision: a request and a load to the same word in the same cycle return the OLD contents (read-before-write). A request in the following cycle returns the new data.
- `busy` = OR of val bits across all pipeline stages.

## Timing
- A request accepted at edge N produces `imemresp_val` = 1 in the cycle after edge N+LATENCY−1.
  - With `LATENCY` = 1: the response is registered and visible in the cycle immediately after the request cycle.
- Reset behaviour:
  - While `rst` = 0, the response pipeline clears asynchronously: `imemresp_val` = 0, `imemresp_data` = 0, `imemresp_err` = 0, `busy` = 0.
  - Array contents are retained.
- Reset mid-operation: all in-flight responses are discarded and never emitted. Requests presented during reset are ignored.
- Reset release: the first rising edge with `rst` = 1 may accept a request.
- Address wrap: none. Addresses ≥ `4*DEPTH_WORDS` return err and never alias to low words.
- `load_en` during reset: ignored.

## Test plan
- Load-then-fetch, `LATENCY` = 1:
  - Stimulus: load 0x0 = `32'h00000513`, 0x4 = `32'h00100593`, 0x8 = `32'h00b50633`; fetch 0x0, 0x4, 0x8 back-to-back.
  - Required: the three words appear on consecutive cycles, each 1 cycle after its request, with err = 0.
- Streaming, `LATENCY` = 3:
  - Stimulus: 8 consecutive fetches 0x0..0x1C, then a 2-cycle gap, then fetch 0x0.
  - Required: responses arrive in order starting 3 cycles after the first request, with no gaps. `busy` is high from the first accept until the last response. The gap is reproduced as exactly 2 invalid response cycles.
- Error cases, `DEPTH_WORDS` = 256:
  - Stimulus: fetch 0x2, then 0x400, then 0x3FC.
  - Required: 0x2 and 0x400 return val = 1, err = 1, data = 0. 0x3FC returns its loaded word with err = 0.
- Collision:
  - Stimulus: word 0x10 holds `32'hAAAAAAAA`. In one cycle, load 0x10 = `32'h55555555` and fetch 0x10. In the next cycle, fetch 0x10 again.
  - Required: the first response is `32'hAAAAAAAA`; the second is `32'h55555555`.
- Reset mid-flight, `LATENCY` = 4:
  - Stimulus: issue 3 fetches, then assert `rst` for 1 cycle between clock edges, then fetch 0x0.
  - Required: all outputs go to 0 immediately on assertion. The 3 in-flight responses are never emitted. The post-reset fetch returns the preloaded word, showing memory is retained.
- Dropped loads:
  - Stimulus: load to 0x6 and to 0x800; then fetch 0x4.
  - Required: 0x4 returns its prior contents unchanged.

Source files
------------

// File: rtl/imem_responder_if.sv
// Fetch-side bus between the F stage (master) and the instruction memory (slave).
// It carries the request address and valid, plus the response valid, data and error flag.
interface imem_responder_if;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        imemresp_err;

  modport master (
    output imemreq_val, imemreq_addr,
    input  imemresp_val, imemresp_data, imemresp_err
  );

  modport slave (
    input  imemreq_val, imemreq_addr,
    output imemresp_val, imemresp_data, imemresp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: combinational array read at accept, then a fixed-latency
// response pipeline. A backdoor port preloads the array; bad addresses are flagged, not aliased.
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  imem_responder_if.slave   imem,
  input  logic              load_en,
  input  logic [31:0]       load_addr,
  input  logic [31:0]       load_data,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH_WORDS);

  // Misaligned or beyond the array: such addresses must never alias onto low words.
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];
  logic        load_ok;
  logic        req_err;
  logic [31:0] rd_data;

  logic        vld_p  [LATENCY];
  logic [31:0] data_p [LATENCY];
  logic        err_p  [LATENCY];

  assign load_ok = load_en && rst && !addr_bad(load_addr);

  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_addr[AW+1:2]] <= load_data;
    end
  end

  // Accept: the array is read before any same-edge load lands, giving read-before-write.
  assign req_err = addr_bad(imem.imemreq_addr);
  assign rd_data = (imem.imemreq_val && !req_err) ? mem[imem.imemreq_addr[AW+1:2]] : '0;

  // Stage 0 through LATENCY-1: shift {val, data, err} toward the output every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
        err_p[i]  <= 1'b0;
      end
    end else begin
      vld_p[0]  <= imem.imemreq_val;
      data_p[0] <= rd_data;
      err_p[0]  <= imem.imemreq_val && req_err;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        data_p[i] <= data_p[i-1];
        err_p[i]  <= err_p[i-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | vld_p[i];
    end
  end

  assign imem.imemresp_val  = vld_p[LATENCY-1];
  assign imem.imemresp_data = data_p[LATENCY-1];
  assign imem.imemresp_err  = err_p[LATENCY-1];
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: three responders (latency 1, 3, 4) share one stimulus stream and are
// each checked cycle by cycle against hand-written expected responses.
module tb_imem_responder;
  logic        clk;
  logic        rst_n;
  logic        req_val;
  logic [31:0] req_addr;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        busy1, busy3, busy4;

  int checks = 0;
  int errors = 0;

  imem_responder_if u_if1 ();
  imem_responder_if u_if3 ();
  imem_responder_if u_if4 ();

  assign u_if1.imemreq_val  = req_val;
  assign u_if1.imemreq_addr = req_addr;
  assign u_if3.imemreq_val  = req_val;
  assign u_if3.imemreq_addr = req_addr;
  assign u_if4.imemreq_val  = req_val;
  assign u_if4.imemreq_addr = req_addr;

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .imem(u_if1), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(busy1));
  imem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst_n), .imem(u_if3), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(busy3));
  imem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst_n), .imem(u_if4), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        le;
    logic [31:0] la;
    logic [31:0] ld;
    logic [31:0] ed;
    logic        ee;
  } step_t;

  step_t tab[$];

  task automatic add(input logic rv, input logic [31:0] ra, input logic le,
                     input logic [31:0] la, input logic [31:0] ld,
                     input logic [31:0] ed, input logic ee);
    step_t s;
    s.rv = rv; s.ra = ra; s.le = le; s.la = la; s.ld = ld; s.ed = ed; s.ee = ee;
    tab.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_dut(input int lat, input int k, input logic v, input logic [31:0] d,
                           input logic e, input logic b);
    int          j;
    logic        ev, ee, eb;
    logic [31:0] ed;
    j  = k - lat + 1;
    ev = 1'b0; ed = '0; ee = 1'b0; eb = 1'b0;
    if (j >= 0 && j < tab.size() && tab[j].rv) begin
      ev = 1'b1; ed = tab[j].ed; ee = tab[j].ee;
    end
    for (int i = k - lat + 1; i <= k; i++) begin
      if (i >= 0 && i < tab.size()) eb = eb | tab[i].rv;
    end
    chk($sformatf("lat%0d step%0d val", lat, k), {31'b0, v}, {31'b0, ev});
    chk($sformatf("lat%0d step%0d data", lat, k), d, ed);
    chk($sformatf("lat%0d step%0d err", lat, k), {31'b0, e}, {31'b0, ee});
    chk($sformatf("lat%0d step%0d busy", lat, k), {31'b0, b}, {31'b0, eb});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " lat1 val"},  {31'b0, u_if1.imemresp_val}, 32'h0);
    chk({tag, " lat1 data"}, u_if1.imemresp_data, 32'h0);
    chk({tag, " lat1 err"},  {31'b0, u_if1.imemresp_err}, 32'h0);
    chk({tag, " lat1 busy"}, {31'b0, busy1}, 32'h0);
    chk({tag, " lat3 val"},  {31'b0, u_if3.imemresp_val}, 32'h0);
    chk({tag, " lat3 data"}, u_if3.imemresp_data, 32'h0);
    chk({tag, " lat3 err"},  {31'b0, u_if3.imemresp_err}, 32'h0);
    chk({tag, " lat3 busy"}, {31'b0, busy3}, 32'h0);
    chk({tag, " lat4 val"},  {31'b0, u_if4.imemresp_val}, 32'h0);
    chk({tag, " lat4 data"}, u_if4.imemresp_data, 32'h0);
    chk({tag, " lat4 err"},  {31'b0, u_if4.imemresp_err}, 32'h0);
    chk({tag, " lat4 busy"}, {31'b0, busy4}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] img [8];
    logic        ev;
    img[0] = 32'h00000513; img[1] = 32'h00100593; img[2] = 32'h00b50633; img[3] = 32'h11111111;
    img[4] = 32'hAAAAAAAA; img[5] = 32'h33333333; img[6] = 32'h44444444; img[7] = 32'h5555AAAA;

    req_val = 1'b0; req_addr = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Program image, then a word near the top of the array.
    for (int i = 0; i < 8; i++) add(1'b0, 32'h0, 1'b1, 32'(i * 4), img[i], 32'h0, 1'b0);
    add(1'b0, 32'h0, 1'b1, 32'h3FC, 32'hDEADBEEF, 32'h0, 1'b0);
    add(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    add(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    // Back-to-back stream, 2-cycle gap, one more fetch.
    for (int i = 0; i < 8; i++) add(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0, img[i], 1'b0);
    add(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    add(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    add(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h00000513, 1'b0);
    // Error classification.
    add(1'b1, 32'h2,        1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    add(1'b1, 32'h400,      1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    add(1'b1, 32'h3FC,      1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    add(1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    // Same-cycle load and fetch of one word, then fetch again.
    add(1'b1, 32'h10, 1'b1, 32'h10, 32'h55555555, 32'hAAAAAAAA, 1'b0);
    add(1'b1, 32'h10, 1'b0, 32'h0,  32'h0,        32'h55555555, 1'b0);
    // Loads that must be dropped, then fetches of the words they would alias onto.
    add(1'b0, 32'h0, 1'b1, 32'h6,   32'hFFFFFFFF, 32'h0, 1'b0);
    add(1'b0, 32'h0, 1'b1, 32'h800, 32'hFFFFFFFF, 32'h0, 1'b0);
    add(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 32'h00100593, 1'b0);
    add(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h00000513, 1'b0);

    for (int k = 0; k < tab.size() + 3; k++) begin
      if (k < tab.size()) begin
        req_val = tab[k].rv; req_addr = tab[k].ra;
        load_en = tab[k].le; load_addr = tab[k].la; load_data = tab[k].ld;
      end else begin
        req_val = 1'b0; req_addr = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
      end
      tick();
      check_dut(1, k, u_if1.imemresp_val, u_if1.imemresp_data, u_if1.imemresp_err, busy1);
      check_dut(3, k, u_if3.imemresp_val, u_if3.imemresp_data, u_if3.imemresp_err, busy3);
      check_dut(4, k, u_if4.imemresp_val, u_if4.imemresp_data, u_if4.imemresp_err, busy4);
    end

    // Three fetches in flight, then an asynchronous reset pulse between edges.
    req_val = 1'b1; req_addr = 32'h4; tick();
    req_addr = 32'h8; tick();
    req_addr = 32'hC; tick();
    req_val = 1'b0; req_addr = '0;
    chk("pre-reset lat1 data", u_if1.imemresp_data, 32'h11111111);
    chk("pre-reset lat3 data", u_if3.imemresp_data, 32'h00100593);
    chk("pre-reset lat4 val",  {31'b0, u_if4.imemresp_val}, 32'h0);
    chk("pre-reset lat4 busy", {31'b0, busy4}, 32'h1);
    #3;
    rst_n = 1'b0;
    req_val = 1'b1; req_addr = 32'h8;
    load_en = 1'b1; load_addr = 32'h0; load_data = 32'hBADBAD00;
    #1;
    check_all_zero("mid-reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    req_val = 1'b1; req_addr = 32'h0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      req_val = 1'b0;
      ev = (k == 0);
      chk($sformatf("post-reset lat1 c%0d val", k), {31'b0, u_if1.imemresp_val}, {31'b0, ev});
      chk($sformatf("post-reset lat1 c%0d data", k), u_if1.imemresp_data, ev ? 32'h00000513 : 32'h0);
      ev = (k == 2);
      chk($sformatf("post-reset lat3 c%0d val", k), {31'b0, u_if3.imemresp_val}, {31'b0, ev});
      chk($sformatf("post-reset lat3 c%0d data", k), u_if3.imemresp_data, ev ? 32'h00000513 : 32'h0);
      ev = (k == 3);
      chk($sformatf("post-reset lat4 c%0d val", k), {31'b0, u_if4.imemresp_val}, {31'b0, ev});
      chk($sformatf("post-reset lat4 c%0d data", k), u_if4.imemresp_data, ev ? 32'h00000513 : 32'h0);
      chk($sformatf("post-reset lat4 c%0d err", k), {31'b0, u_if4.imemresp_err}, 32'h0);
      chk($sformatf("post-reset lat4 c%0d busy", k), {31'b0, busy4}, {31'b0, (k <= 3)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
